// File: rtl/axil_selftest_master_if.sv
// AXI4-Lite master-side bus bundle for the self-test master.
interface axil_selftest_master_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic [ADDR_W-1:0] M_AXI_AWADDR;
   logic [2:0]        M_AXI_AWPROT;
   logic              M_AXI_AWVALID;
   logic              M_AXI_AWREADY;
   logic [31:0]       M_AXI_WDATA;
   logic [3:0]        M_AXI_WSTRB;
   logic              M_AXI_WVALID;
   logic              M_AXI_WREADY;
   logic [1:0]        M_AXI_BRESP;
   logic              M_AXI_BVALID;
   logic              M_AXI_BREADY;
   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic [2:0]        M_AXI_ARPROT;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;
   logic [31:0]       M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;

   modport master (
      output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
   );

   modport slave (
      input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, output M_AXI_RVALID, input M_AXI_RREADY
   );
endinterface

// File: rtl/axil_selftest_master.sv
// AXI4-Lite self-test master: writes a counting pattern to C_NUM_REGS registers, reads it back and counts errors.
// Optional watchdog enabled by defining SELFTEST_TIMEOUT_EN.
module axil_selftest_master #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_NUM_REGS         = 4,
   parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
   parameter logic [31:0] C_START_DATA       = 32'h0000_0001
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [7:0]                    err_count,
   axil_selftest_master_if.master        m_axi
);
   localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned DATA_W = C_M_AXI_DATA_WIDTH;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned ERR_W  = 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REGS - 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
`ifdef SELFTEST_TIMEOUT_EN
   logic [15:0]         wd_q, wd_d;
`endif

   function automatic logic [ADDR_W-1:0] reg_addr(input logic [IDX_W-1:0] idx);
      return ADDR_W'(C_BASE_ADDR) + ADDR_W'({idx, 2'b00});
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      err_d     = err_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      pass_d    = pass_q;
      aw_hs     = awvalid_q & m_axi.M_AXI_AWREADY;
      w_hs      = wvalid_q  & m_axi.M_AXI_WREADY;
      b_hs      = bready_q  & m_axi.M_AXI_BVALID;
      ar_hs     = arvalid_q & m_axi.M_AXI_ARREADY;
      r_hs      = rready_q  & m_axi.M_AXI_RVALID;
`ifdef SELFTEST_TIMEOUT_EN
      wd_d      = '0;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = WR_REQ;
               idx_d     = '0;
               data_d    = DATA_W'(C_START_DATA);
               err_d     = '0;
               pass_d    = 1'b0;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               awaddr_d  = reg_addr('0);
               wdata_d   = DATA_W'(C_START_DATA);
               wstrb_d   = 4'hF;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; leave once both are accepted
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               bready_d = 1'b0;
               if (m_axi.M_AXI_BRESP != 2'b00) err_d = sat_inc(err_q);
               idx_d  = idx_q + IDX_W'(1);
               data_d = data_q + DATA_W'(1);
               if (idx_q == LAST_IDX) begin
                  idx_d     = '0;
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
                  araddr_d  = reg_addr('0);
               end else begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  awaddr_d  = reg_addr(idx_q + IDX_W'(1));
                  wdata_d   = data_q + DATA_W'(1);
               end
            end
         end
         RD_REQ: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (r_hs) begin
               rready_d = 1'b0;
               // Data mismatch and error response in one beat count once
               if ((m_axi.M_AXI_RDATA != (DATA_W'(C_START_DATA) + DATA_W'(idx_q))) ||
                   (m_axi.M_AXI_RRESP != 2'b00))
                  err_d = sat_inc(err_q);
               if (idx_q == LAST_IDX) begin
                  state_d = FINISH;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  arvalid_d = 1'b1;
                  araddr_d  = reg_addr(idx_q + IDX_W'(1));
                  state_d   = RD_REQ;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef SELFTEST_TIMEOUT_EN
      // Watchdog: stalled bus aborts the test with one extra error
      if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) begin
         if (aw_hs | w_hs | b_hs | ar_hs | r_hs) begin
            wd_d = '0;
         end else if (wd_q == 16'hFFFE) begin
            wd_d      = 16'hFFFF;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            err_d     = sat_inc(err_q);
            state_d   = FINISH;
         end else begin
            wd_d = wd_q + 16'd1;
         end
      end
`endif

      busy_d = (state_d != IDLE);
      done_d = (state_d == FINISH);
      if ((state_d == FINISH) && (state_q != FINISH)) pass_d = (err_d == '0);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         data_q    <= '0;
         err_q     <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
`ifdef SELFTEST_TIMEOUT_EN
         wd_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         err_q     <= err_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
`ifdef SELFTEST_TIMEOUT_EN
         wd_q      <= wd_d;
`endif
      end
   end

   assign busy                = busy_q;
   assign done                = done_q;
   assign pass                = pass_q;
   assign err_count           = err_q;
   assign m_axi.M_AXI_AWADDR  = awaddr_q;
   assign m_axi.M_AXI_AWPROT  = 3'b000;
   assign m_axi.M_AXI_AWVALID = awvalid_q;
   assign m_axi.M_AXI_WDATA   = wdata_q;
   assign m_axi.M_AXI_WSTRB   = wstrb_q;
   assign m_axi.M_AXI_WVALID  = wvalid_q;
   assign m_axi.M_AXI_BREADY  = bready_q;
   assign m_axi.M_AXI_ARADDR  = araddr_q;
   assign m_axi.M_AXI_ARPROT  = 3'b000;
   assign m_axi.M_AXI_ARVALID = arvalid_q;
   assign m_axi.M_AXI_RREADY  = rready_q;
endmodule

// File: doc/axil_selftest_master.md
AXIL_SELFTEST_MASTER -- requirements
Module: axil_selftest_master

Interface
REQ-001 C_M_AXI_ADDR_WIDTH, 32, master address width.
REQ-002 C_M_AXI_DATA_WIDTH, 32, master data width; only 32 is supported.
REQ-003 C_NUM_REGS, 4, number of consecutive slave registers tested (1..16).
REQ-004 C_BASE_ADDR, 0, byte address of the first register; stride is 4.
REQ-005 C_START_DATA, 32'h00000001, data written to the first register; each next register receives +1.
REQ-006 Clock and reset SHALL be one clock and an asynchronous, active-low reset: ACLK in 1 (the single clock) and ARESETN in 1 (asynchronous, active-low reset).
REQ-007 Control ports SHALL be:
- start in 1: pulse to launch a test.
- busy out 1: test in progress.
- done out 1: one-cycle completion pulse.
- pass out 1: result of the last test, held until the next start.
- err_count out 8: mismatches plus error responses, saturating at 255.
REQ-008 AXI4-Lite master ports SHALL be:
- M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Function
REQ-009 The FSM SHALL have the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and FINISH.
REQ-010 In IDLE, start=1 SHALL:
- clear err_count and the register index;
- load the data register with C_START_DATA;
- go to WR_REQ on the next edge.
While busy=1, start SHALL be ignored.
REQ-011 WR_REQ SHALL assert AWVALID and WVALID together, with:
- AWADDR = C_BASE_ADDR + 4*index;
- WDATA = the current data register;
- WSTRB = 4'hF;
- AWPROT = 0.
REQ-012 AWVALID and WVALID SHALL each drop on the cycle after its own handshake; WR_REQ SHALL go to WR_RESP once both handshakes are complete, including when both occur in the same cycle.
REQ-013 In WR_RESP, BREADY SHALL be 1, and a BVALID handshake SHALL:
- add 1 to err_count if BRESP != OKAY;
- increment index and data;
- return to WR_REQ, or go to RD_REQ with index reset to 0 when index = C_NUM_REGS-1.
REQ-014 RD_REQ SHALL assert ARVALID with ARADDR = C_BASE_ADDR + 4*index and ARPROT = 0, and go to RD_RESP on the ARREADY handshake.
REQ-015 In RD_RESP, RREADY SHALL be 1, and an RVALID handshake SHALL:
- compare RDATA against C_START_DATA + index;
- add 1 to err_count on a mismatch or RRESP != OKAY, counting 1 when both occur in the same beat;
- advance index, or go to FINISH after the last register.
REQ-016 FINISH SHALL pulse done for one cycle, set pass = (err_count == 0) and return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 VALID SHALL never depend combinationally on READY: every VALID is a registered output and stays asserted until its handshake.
REQ-019 At most one transaction SHALL be outstanding; the master never issues AR while a write is pending.
REQ-020 The latency from start to the first AWVALID SHALL be 1 cycle.

Reset
REQ-021 When ARESETN=0, at any time including mid-transaction, the block SHALL asynchronously:
- drive every VALID and READY output to 0;
- set busy, done, pass and err_count to 0;
- set AWADDR, ARADDR and WDATA to 0, WSTRB to 0 and the PROT outputs to 0;
- enter IDLE.
REQ-022 After reset the block SHALL wait for a new start.

Configuration
REQ-023 With SELFTEST_TIMEOUT_EN defined, a 16-bit watchdog SHALL:
- count cycles spent in any non-IDLE, non-FINISH state without a handshake, clearing on each handshake;
- on reaching 16'hFFFF, drop all VALID/READY outputs, add 1 to err_count and go to FINISH (pass=0).
REQ-024 With SELFTEST_TIMEOUT_EN undefined, the watchdog SHALL be absent, and the block waits indefinitely for a handshake.

Verification
REQ-025 A loopback 4-register slave with a ready slave and a start pulse SHALL produce writes of 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads of the same values, followed by done, pass=1 and err_count=0.
REQ-026 A slave that returns 0xDEADBEEF from register 2 SHALL produce err_count=1 and pass=0.
REQ-027 A slave with AWREADY delayed 3 cycles after WREADY SHALL see WVALID drop after its own handshake with no duplicate W beat, and the test SHALL pass.
REQ-028 A slave with BRESP=SLVERR on the first write SHALL produce err_count=1 and pass=0.
REQ-029 ARESETN driven low while in RD_RESP SHALL drop all outputs to 0 with busy=0; a new start SHALL rerun the test and pass.
REQ-030 With SELFTEST_TIMEOUT_EN defined and ARREADY held at 0, done SHALL pulse 65535 cycles after ARVALID rises, with err_count=1 and pass=0.
